// File: rtl/uart_tx_word_ser_if.sv
// Core-side word handshake for uart_tx_word_ser.
//   out_valid : core presents a word
//   out_data  : 32-bit word to transmit
//   out_size  : (UART_TX_SER_SIZE_EN only) byte count minus one
//   out_ready : serializer can accept a word this cycle
// master = core side, slave = serializer side.
interface uart_tx_word_ser_if;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef UART_TX_SER_SIZE_EN
    logic [1:0]  out_size;

    modport master (output out_valid, output out_data, output out_size, input out_ready);
    modport slave  (input out_valid, input out_data, input out_size, output out_ready);
`else
    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
`endif
endinterface

// File: rtl/uart_tx_word_ser.sv
// uart_tx_word_ser: splits 32-bit core output words into bytes and strobes
// them into the buffered UART transmit top, one tx_start pulse every GAP
// cycles so that every pulse lands while its write machine is idle.
//
// Ports:
//   clk      : system clock
//   rstn     : asynchronous active-low reset
//   out_if   : word handshake (slave modport): out_valid/out_data in,
//              out_ready out (registered, high only in S_IDLE)
//   tx_start : one-cycle byte strobe
//   tx_data  : byte for tx_start, held between strobes
//   busy     : high while a word (including its trailing gap) is in flight
//
// Parameters: BYTES (1..4), BIG_ENDIAN (0/1), GAP (3..15).
// Optional: define UART_TX_SER_SIZE_EN to add out_size[1:0]; each word then
// sends min(out_size+1, BYTES) bytes.
module uart_tx_word_ser #(
    parameter int BYTES      = 4,
    parameter int BIG_ENDIAN = 0,
    parameter int GAP        = 3
) (
    input  logic                clk,
    input  logic                rstn,
    uart_tx_word_ser_if.slave   out_if,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    output logic                busy
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    localparam logic [1:0] LAST_FULL = 2'(BYTES - 1);
    // The pulse cycle itself plus GAP-1 countdown cycles (GAP-2 .. 0).
    localparam logic [3:0] GAP_LOAD  = 4'(GAP - 2);

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  last;       // index of the final byte of the current word
    logic [3:0]  gap_cnt;
    logic [31:0] word;
    logic        ready_q;
    logic [1:0]  new_last;

    assign out_if.out_ready = ready_q;

`ifdef UART_TX_SER_SIZE_EN
    // min(out_size+1, BYTES) bytes -> last index min(out_size, BYTES-1)
    assign new_last = (out_if.out_size < LAST_FULL) ? out_if.out_size : LAST_FULL;
`else
    assign new_last = LAST_FULL;
`endif

    // Byte i of a word whose final index is l; big-endian walks down from l.
    function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i,
                                        input logic [1:0] l);
        logic [1:0] s;
        logic [7:0] b;
        s = (BIG_ENDIAN != 0) ? (l - i) : i;
        case (s)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Outputs are computed from the next state so they line up with it:
    // tx_start is high exactly in the S_SEND cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            idx      <= 2'd0;
            last     <= 2'd0;
            gap_cnt  <= 4'd0;
            word     <= 32'd0;
            ready_q  <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ready_q && out_if.out_valid) begin
                        word     <= out_if.out_data;
                        last     <= new_last;
                        idx      <= 2'd0;
                        state    <= S_SEND;
                        tx_start <= 1'b1;
                        tx_data  <= pick(out_if.out_data, 2'd0, new_last);
                        ready_q  <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        // first cycle after reset release raises ready here
                        ready_q  <= 1'b1;
                    end
                end
                S_SEND: begin
                    gap_cnt <= GAP_LOAD;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else if (idx == last) begin
                        // trailing gap done: next word may start right away
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        idx      <= idx + 2'd1;
                        state    <= S_SEND;
                        tx_start <= 1'b1;
                        tx_data  <= pick(word, idx + 2'd1, last);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_word_ser.md
Name: uart_tx_word_ser

Overview:
- Upstream feeder for the buffered UART transmit top.
- Accepts 32-bit output words from the core's output instruction through a valid/ready handshake.
- Splits each word into bytes and issues one single-cycle tx_start pulse per byte, with the byte on tx_data.
- Pulses are spaced so that every pulse lands while the transmit top's write state machine is idle. That machine needs 3 cycles per byte: idle, wait, wrote.

Parameters:
- BYTES, 4, bytes sent per word; legal 1..4; bytes above BYTES are ignored.
- BIG_ENDIAN, 0, 0 sends out_data[7:0] first; 1 sends the highest used byte first (out_data[8*BYTES-1 -: 8]).
- GAP, 3, cycles from one tx_start pulse to the next, including the pulse cycle; legal 3..15.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- out_valid  input  1  core presents a word
- out_data  input  32  word to transmit
- out_ready  output  1  block can accept a word this cycle
- tx_start  output  1  one-cycle byte strobe to the UART transmit top
- tx_data  output  8  byte accompanying tx_start
- busy  output  1  high while a word is being serialized or the trailing gap is running

Behaviour:
- Reset
  - One clock; reset is asynchronous and active-low on rstn.
  - Outputs while rstn=0: out_ready=0, tx_start=0, tx_data=8'h00, busy=0.
  - Internal state while rstn=0: state=S_IDLE, byte index=0, gap counter=0, word latch=0.
  - out_ready rises in the first cycle after rstn deasserts. It is out_ready = (state==S_IDLE), registered.
- Outputs are registered. tx_data holds its last value when tx_start=0.
- States:
  - S_IDLE
    - out_ready=1, busy=0.
    - If out_valid=1: latch out_data, set index=0, go to S_SEND.
    - If out_valid=0: stay.
  - S_SEND
    - tx_start=1 for exactly this cycle; tx_data = selected byte of the latched word.
    - Load gap counter with GAP-2 and go to S_GAP.
  - S_GAP
    - tx_start=0; count the gap counter down.
    - When it reaches 0: if index==BYTES-1, go to S_IDLE; otherwise increment index and go to S_SEND.
- Byte selection
  - index i selects byte i when BIG_ENDIAN=0, and byte BYTES-1-i when BIG_ENDIAN=1.
- Timing for a word accepted at edge a (GAP=3, BYTES=4)
  - tx_start pulses in cycles a+1, a+4, a+7, a+10.
  - out_ready is high again in cycle a+13.
  - Next word's first pulse is no earlier than a+14.
  - General form: pulse spacing is exactly GAP cycles; a word occupies BYTES*GAP cycles from first pulse to out_ready.
- Trailing gap: a full gap always follows the last byte, so back-to-back words never violate the spacing.
- out_valid while out_ready=0 is ignored; the core must hold the word until accepted.
- Mid-word changes: changes on out_data or out_valid during S_SEND or S_GAP have no effect on the word being sent.
- Reset mid-word: the remaining bytes are discarded; tx_start drops asynchronously.
- busy=1 in S_SEND and S_GAP.

Optional Feature:
- Macro: UART_TX_SER_SIZE_EN.
- Defined
  - Adds input out_size[1:0], sampled together with out_data at accept.
  - The word sends min(out_size+1, BYTES) bytes.
  - Big-endian order starts from byte (count-1).
- Undefined
  - Port absent; every word sends exactly BYTES bytes.

Test Plan:
- Reset, then out_valid=1 with out_data=32'h44332211 at edge a, defaults -> tx_data 11,22,33,44 on pulses at a+1, a+4, a+7, a+10; out_ready=1 at a+13.
- BIG_ENDIAN=1, same word -> pulse order 44,33,22,11 with the same timing.
- Back-to-back words 32'hA1A2A3A4 then 32'hB1B2B3B4 with out_valid held high -> 8 pulses, all spaced 3 cycles; the second word is accepted at a+13.
- GAP=5, BYTES=2, word 32'h0000BEEF -> pulses EF then BE, 5 cycles apart; busy stays high for 10 cycles.
- rstn pulled low 1 cycle after the second pulse of a 4-byte word -> tx_start=0 immediately; no further pulses; out_ready=1 in the first cycle after release; the next word restarts at byte 0.
- UART_TX_SER_SIZE_EN defined, out_size=2'd0 with word 32'h000000FF -> exactly one pulse with FF; out_ready returns 3 cycles after that pulse.
